fpadd_pipe: RTL and testbench
=============================

FPADD_PIPE -- requirements
Module: fpadd_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored fraction width (hidden bit implicit).
REQ-003 SHALL derive W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1 (local, not overridable).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  pipeline accepts operands this cycle.
REQ-008 oprA  in  W  operand A, {sign, exp, frac}.
REQ-009 oprB  in  W  operand B, same format.
REQ-010 op_sub  in  1  1 = compute A-B (sign of B inverted), 0 = A+B.
REQ-011 out_valid  out  1  Result valid.
REQ-012 out_ready  in  1  downstream accepts Result.
REQ-013 Result  out  W  rounded sum.
REQ-014 flags  out  4  {invalid, overflow, underflow, inexact}, aligned with Result.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/compare/align, S2 signed mantissa add, S3 normalise/round/pack; latency exactly 3 cycles with no stall.
REQ-016 Pipeline advance SHALL be: adv = !out_valid | out_ready; all stages shift only when adv=1; in_ready = adv.
REQ-017 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready; bubbles propagate as invalid stages.
REQ-018 While adv=0, Result, flags, out_valid and all stage registers SHALL hold unchanged.
REQ-019 Throughput SHALL be one result per cycle with out_ready held high.
REQ-020 Exp field 0 SHALL be treated as zero (denormal inputs flushed to signed zero).
REQ-021 Exp field all-ones with frac=0 SHALL be infinity; with frac!=0 SHALL be NaN.
REQ-022 Alignment SHALL shift smaller-magnitude mantissa right by exp difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 SHALL collapse to sticky only.
REQ-023 Rounding SHALL be round-to-nearest-even; mantissa carry out of rounding SHALL increment exponent.
REQ-024 Exact cancellation SHALL give +0; -0 + -0 SHALL give -0.
REQ-025 Biased result exponent >= all-ones SHALL give signed infinity, overflow=1, inexact=1.
REQ-026 Biased result exponent <= 0 SHALL give signed zero, underflow=1, inexact=1.
REQ-027 Any NaN input, or inf minus inf (after op_sub applied), SHALL give canonical NaN {0, all-ones, 1 followed by zeros}, invalid=1.
REQ-028 inf plus finite SHALL give that inf, no flags.
REQ-029 inexact SHALL be 1 when any of guard/round/sticky discarded is non-zero.
REQ-030 flags SHALL be 0 whenever out_valid=0.

Reset
REQ-031 rst=1 SHALL asynchronously clear all stage valid bits, out_valid=0, Result=0, flags=0; in_ready=1 from reset.
REQ-032 Operands in flight at reset assertion SHALL be discarded; no Result SHALL emerge for them after release.
REQ-033 First transfer after reset SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-034 oprA=3C00, oprB=4000, op_sub=0, out_ready=1 -> Result=4200 exactly 3 cycles later, flags=0000.
REQ-035 oprA=3C00, oprB=3C00, op_sub=1 -> Result=0000, flags=0000; oprA=3C00, oprB=1000 -> Result=3C00, inexact=1 (tie to even); oprA=3C00, oprB=1200 -> Result=3C01, inexact=1.
REQ-036 oprA=7BFF, oprB=7BFF -> Result=7C00, flags=0101; oprA=7C00, oprB=7C00, op_sub=1 -> Result=7E00, flags=1000.
REQ-037 Stream 8 back-to-back pairs, out_ready low for 5 cycles mid-stream -> in_ready low while full, Result held stable, all 8 results delivered in order, none lost or duplicated.
REQ-038 Assert rst with 3 operations in flight -> out_valid=0 next sample, zero results for those operations after release, next pair 4000+4000 -> 4400.
REQ-039 Re-instantiate with EXP_W=8, MAN_W=7: oprA=3F80, oprB=4000 -> Result=4040; oprA=7F7F, oprB=7F7F -> Result=7F80, overflow=1.

Source files
------------

// File: rtl/fpadd_pipe_if.sv
// Operand/result handshake bundle for fpadd_pipe: operands in with valid/ready,
// rounded result and exception flags out with valid/ready.
interface fpadd_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] oprA;
  logic [W-1:0] oprB;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [3:0]   flags;

  modport slave (
    input  in_valid, oprA, oprB, op_sub, out_ready,
    output in_ready, out_valid, Result, flags
  );

  modport master (
    output in_valid, oprA, oprB, op_sub, out_ready,
    input  in_ready, out_valid, Result, flags
  );
endinterface

// File: rtl/fpadd_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round) with
// round-to-nearest-even, flush-to-zero inputs and a single global stall.
module fpadd_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  fpadd_pipe_if.slave  bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int MW   = MAN_W + 4;        // hidden + fraction + guard/round/sticky
  localparam int SW   = MAN_W + 5;        // MW plus carry
  localparam int XW   = EXP_W + $clog2(SW) + 2;
  localparam int EMAX = 2**EXP_W - 1;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: unpack, compare, align ----------------
  logic               sa, sb, za, zb, inf_a, inf_b, nan_a, nan_b, a_big;
  logic [EXP_W-1:0]   ea, eb, e_big, e_small, diff;
  logic [MAN_W-1:0]   fa, fb;
  logic [MW-1:0]      ma, mb, m_big, m_small, m_align;

  assign sa    = bus.oprA[W-1];
  assign ea    = bus.oprA[W-2 -: EXP_W];
  assign fa    = bus.oprA[MAN_W-1:0];
  assign sb    = bus.oprB[W-1] ^ bus.op_sub;
  assign eb    = bus.oprB[W-2 -: EXP_W];
  assign fb    = bus.oprB[MAN_W-1:0];
  assign za    = (ea == '0);
  assign zb    = (eb == '0);
  assign inf_a = (ea == '1) && (fa == '0);
  assign inf_b = (eb == '1) && (fb == '0);
  assign nan_a = (ea == '1) && (fa != '0);
  assign nan_b = (eb == '1) && (fb != '0);
  assign ma    = za ? '0 : {1'b1, fa, 3'b000};
  assign mb    = zb ? '0 : {1'b1, fb, 3'b000};
  assign a_big = {ea, ma} >= {eb, mb};

  always_comb begin
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_small = a_big ? mb : ma;
    diff    = e_big - e_small;
    // Beyond MAN_W+3 positions the whole small operand lands below sticky.
    if (32'(diff) >= MAN_W + 3)
      m_align = {{(MW-1){1'b0}}, |m_small};
    else
      m_align = (m_small >> diff) |
                {{(MW-1){1'b0}}, |(m_small & ~({MW{1'b1}} << diff))};
  end

  logic             v1, nan1, inf1, infs1, sbig1, eff_sub1;
  logic [EXP_W-1:0] e1;
  logic [MW-1:0]    mbig1, msml1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; nan1 <= 1'b0; inf1 <= 1'b0; infs1 <= 1'b0;
      sbig1 <= 1'b0; eff_sub1 <= 1'b0; e1 <= '0; mbig1 <= '0; msml1 <= '0;
    end else if (adv) begin
      v1       <= bus.in_valid;
      nan1     <= nan_a || nan_b || (inf_a && inf_b && (sa != sb));
      inf1     <= inf_a || inf_b;
      infs1    <= inf_a ? sa : sb;
      sbig1    <= a_big ? sa : sb;
      eff_sub1 <= (sa != sb);
      e1       <= e_big;
      mbig1    <= m_big;
      msml1    <= m_align;
    end
  end

  // ---------------- S2: signed mantissa add ----------------
  logic [SW-1:0]        sum;
  logic                 sum_sign;
  logic signed [XW-1:0] exp_unb;

  always_comb begin
    sum      = eff_sub1 ? ({1'b0, mbig1} - {1'b0, msml1})
                        : ({1'b0, mbig1} + {1'b0, msml1});
    // Exact cancellation rounds to +0; like-signed zeros keep their sign.
    sum_sign = (sum == '0 && eff_sub1) ? 1'b0 : sbig1;
    exp_unb  = $signed({{(XW-EXP_W){1'b0}}, e1}) - XW'(BIAS);
  end

  logic                 v2, nan2, inf2, infs2, sign2;
  logic signed [XW-1:0] exp2;
  logic [SW-1:0]        sum2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; nan2 <= 1'b0; inf2 <= 1'b0; infs2 <= 1'b0;
      sign2 <= 1'b0; exp2 <= '0; sum2 <= '0;
    end else if (adv) begin
      v2    <= v1;
      nan2  <= nan1;
      inf2  <= inf1;
      infs2 <= infs1;
      sign2 <= sum_sign;
      exp2  <= exp_unb;
      sum2  <= sum;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  function automatic int lead_one(input logic [SW-1:0] x);
    int p;
    p = 0;
    for (int i = 0; i < SW; i++)
      if (x[i]) p = i;
    return p;
  endfunction

  int                   lz;
  logic [MW-1:0]        norm;
  logic signed [XW-1:0] exp_n, exp_r;
  logic                 g, r, st, rnd, inexact;
  logic [MAN_W+1:0]     mr;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         res;
  logic [3:0]           flg;

  always_comb begin
    lz = 0;
    if (sum2[SW-1]) begin
      norm  = {sum2[SW-1:2], sum2[1] | sum2[0]};
      exp_n = exp2 + XW'(1);
    end else begin
      lz    = MW - 1 - lead_one(sum2);
      norm  = sum2[MW-1:0] << lz;
      exp_n = exp2 - XW'(lz);
    end
    g       = norm[2];
    r       = norm[1];
    st      = norm[0];
    rnd     = g && (r || st || norm[3]);
    inexact = g || r || st;
    mr      = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    frac_r  = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    exp_r   = exp_n + XW'(BIAS) + $signed({{(XW-1){1'b0}}, mr[MAN_W+1]});
    res     = {sign2, exp_r[EXP_W-1:0], frac_r};
    flg     = {3'b000, inexact};
    if (nan2) begin
      res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg = 4'b1000;
    end else if (inf2) begin
      res = {infs2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0000;
    end else if (sum2 == '0) begin
      res = {sign2, {(W-1){1'b0}}};
      flg = 4'b0000;
    end else if (exp_r >= $signed(XW'(EMAX))) begin
      res = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end else if (exp_r <= $signed(XW'(0))) begin
      res = {sign2, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  logic         res_valid;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else if (adv) begin
      res_valid <= v2;
      res_data  <= v2 ? res : '0;
      res_flags <= v2 ? flg : 4'b0000;
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.Result    = res_data;
  assign bus.flags     = res_flags;
endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe: half-precision and bfloat16 instances, directed
// vectors, a mid-stream output stall and reset with operations in flight.
module tb_fpadd_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpadd_pipe_if #(.EXP_W(5), .MAN_W(10)) h ();
  fpadd_pipe_if #(.EXP_W(8), .MAN_W(7))  b ();

  fpadd_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(h.slave));
  fpadd_pipe #(.EXP_W(8), .MAN_W(7))  dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q_h[$];
  exp_t        q_b[$];
  exp_t        e_h, e_b;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  bit          stalled = 1'b0;
  logic [15:0] held_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor for the half-precision instance
  always @(negedge clk) begin
    if (!rst) begin
      if (h.out_valid && h.out_ready) begin
        if (q_h.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: got %h, required no result", h.Result);
        end else begin
          e_h = q_h.pop_front();
          check("result", {16'h0, h.Result}, {16'h0, e_h.res});
          check("flags", {28'h0, h.flags}, {28'h0, e_h.flg});
          if (e_h.lat) check("latency", cyc - e_h.cyc, 3);
          $display("half result %h flags %b (expected %h %b)", h.Result, h.flags, e_h.res, e_h.flg);
        end
      end
      if (!h.out_valid) check("flags_idle", {28'h0, h.flags}, 32'h0);
      if (h.out_valid && !h.out_ready) begin
        check("in_ready_stall", {31'h0, h.in_ready}, 32'h0);
        if (stalled) check("result_hold", {16'h0, h.Result}, {16'h0, held_res});
        held_res = h.Result;
        stalled  = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Monitor for the bfloat16 instance
  always @(negedge clk) begin
    if (!rst && b.out_valid && b.out_ready) begin
      if (q_b.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result_bf16: got %h, required no result", b.Result);
      end else begin
        e_b = q_b.pop_front();
        check("result_bf16", {16'h0, b.Result}, {16'h0, e_b.res});
        check("flags_bf16", {28'h0, b.flags}, {28'h0, e_b.flg});
        if (e_b.lat) check("latency_bf16", cyc - e_b.cyc, 3);
        $display("bf16 result %h flags %b (expected %h %b)", b.Result, b.flags, e_b.res, e_b.flg);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that takes the pair.
  task automatic send(input bit bf, input logic [15:0] a, input logic [15:0] bb, input bit sub,
                      input logic [15:0] res, input logic [3:0] flg, input bit lat);
    int   n;
    logic rdy;
    exp_t e;
    if (bf) begin b.in_valid = 1'b1; b.oprA = a; b.oprB = bb; b.op_sub = sub; end
    else    begin h.in_valid = 1'b1; h.oprA = a; h.oprB = bb; h.op_sub = sub; end
    n = 0;
    @(negedge clk);
    rdy = bf ? b.in_ready : h.in_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = bf ? b.in_ready : h.in_ready;
    end
    if (!rdy) begin
      total_cnt++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end else begin
      e.res = res; e.flg = flg; e.cyc = cyc; e.lat = lat;
      if (bf) q_b.push_back(e); else q_h.push_back(e);
    end
    @(posedge clk);
    #1;
    if (bf) b.in_valid = 1'b0; else h.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_h.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_h.size() != 0 || q_b.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q_h.size() + q_b.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    h.in_valid = 1'b0; h.oprA = '0; h.oprB = '0; h.op_sub = 1'b0; h.out_ready = 1'b1;
    b.in_valid = 1'b0; b.oprA = '0; b.oprB = '0; b.op_sub = 1'b0; b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'h0, h.out_valid}, 32'h0);
    check("reset_result", {16'h0, h.Result}, 32'h0);
    check("reset_flags", {28'h0, h.flags}, 32'h0);
    check("reset_in_ready", {31'h0, h.in_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed half-precision vectors, issued back to back
    send(0, 16'h3C00, 16'h4000, 0, 16'h4200, 4'b0000, 1);
    send(0, 16'h3C00, 16'h3C00, 1, 16'h0000, 4'b0000, 1);
    send(0, 16'h3C00, 16'h1000, 0, 16'h3C00, 4'b0001, 1);
    send(0, 16'h3C00, 16'h1200, 0, 16'h3C01, 4'b0001, 1);
    send(0, 16'h7BFF, 16'h7BFF, 0, 16'h7C00, 4'b0101, 1);
    send(0, 16'h7C00, 16'h7C00, 1, 16'h7E00, 4'b1000, 1);
    send(0, 16'h7C00, 16'h3C00, 0, 16'h7C00, 4'b0000, 1);
    send(0, 16'h7E01, 16'h3C00, 0, 16'h7E00, 4'b1000, 1);
    send(0, 16'h8000, 16'h8000, 0, 16'h8000, 4'b0000, 1);
    send(0, 16'h0000, 16'h8000, 0, 16'h0000, 4'b0000, 1);
    send(0, 16'h3C00, 16'h4000, 1, 16'hBC00, 4'b0000, 1);
    send(0, 16'h0500, 16'h0400, 1, 16'h0000, 4'b0011, 1);
    send(0, 16'h0001, 16'h3C00, 0, 16'h3C00, 4'b0000, 1);
    send(0, 16'h3C01, 16'h1000, 0, 16'h3C02, 4'b0001, 1);
    send(0, 16'h3BFF, 16'h0C00, 0, 16'h3C00, 4'b0001, 1);
    send(0, 16'h3C00, 16'h0400, 1, 16'h3C00, 4'b0001, 1);
    send(0, 16'hFC00, 16'h7BFF, 0, 16'hFC00, 4'b0000, 1);
    send(0, 16'h7C00, 16'hFC00, 0, 16'h7E00, 4'b1000, 1);
    send(0, 16'hFBFF, 16'h7BFF, 1, 16'hFC00, 4'b0101, 1);
    drain();

    // Eight back-to-back pairs with a 5-cycle output stall mid-stream
    fork
      begin
        send(0, 16'h4000, 16'h4000, 0, 16'h4400, 4'b0000, 0);
        send(0, 16'h4200, 16'h3C00, 0, 16'h4400, 4'b0000, 0);
        send(0, 16'h4400, 16'h4400, 0, 16'h4800, 4'b0000, 0);
        send(0, 16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000, 0);
        send(0, 16'h4000, 16'h3C00, 1, 16'h3C00, 4'b0000, 0);
        send(0, 16'h4200, 16'h4000, 1, 16'h3C00, 4'b0000, 0);
        send(0, 16'h4800, 16'h4400, 1, 16'h4400, 4'b0000, 0);
        send(0, 16'h3800, 16'h3800, 0, 16'h3C00, 4'b0000, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 h.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 h.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight; none of them may emerge
    send(0, 16'h4000, 16'h3C00, 0, 16'h4200, 4'b0000, 0);
    send(0, 16'h4200, 16'h4200, 0, 16'h4600, 4'b0000, 0);
    send(0, 16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000, 0);
    #1 rst = 1'b1;
    q_h.delete();
    #1;
    check("async_reset_out_valid", {31'h0, h.out_valid}, 32'h0);
    check("async_reset_result", {16'h0, h.Result}, 32'h0);
    check("async_reset_flags", {28'h0, h.flags}, 32'h0);
    @(negedge clk);
    check("reset_in_ready_held", {31'h0, h.in_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 16'h4000, 16'h4000, 0, 16'h4400, 4'b0000, 1);
    drain();

    // bfloat16 instance
    send(1, 16'h3F80, 16'h4000, 0, 16'h4040, 4'b0000, 1);
    send(1, 16'h7F7F, 16'h7F7F, 0, 16'h7F80, 4'b0101, 1);
    send(1, 16'hC000, 16'h3F80, 0, 16'hBF80, 4'b0000, 1);
    send(1, 16'h3F80, 16'h3F80, 1, 16'h0000, 4'b0000, 1);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
